key_counter_ctrl: RTL and testbench

KEY_COUNTER_CTRL -- requirements
Module: key_counter_ctrl

---
 rtl/key_counter_ctrl_pkg.sv | 35 +++
 rtl/bcd4_step.sv | 51 +++++
 rtl/key_counter_ctrl.sv | 119 +++++++++++
 tb/tb_key_counter_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_counter_ctrl_pkg.sv
// Shared definitions for the key-driven BCD up/down counter.
// Holds the keyboard codes that act as commands, the controller state
// encoding, parameter defaults and the state-to-LED decode.
package key_counter_ctrl_pkg;

  // {extend, scancode} of the two command keys
  localparam logic [8:0] KeyK1 = 9'h069;
  localparam logic [8:0] KeyK2 = 9'h072;

  // 0.1 s at 100 MHz
  localparam int unsigned TickDivDefault = 10_000_000;
  localparam logic [15:0] LimitDefault   = 16'h9999;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown,
    StHold
  } state_e;

  // LED nibble order is {IDLE, UP, DOWN, HOLD}, MSB first
  function automatic logic [3:0] state_onehot(state_e s);
    logic [3:0] oh;
    oh = 4'b0000;
    unique case (s)
      StIdle:  oh = 4'b1000;
      StUp:    oh = 4'b0100;
      StDown:  oh = 4'b0010;
      StHold:  oh = 4'b0001;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bcd4_step.sv
// Combinational four-digit BCD +1 / -1 with saturation.
// Ports:
//   value  - current count, four BCD digits, [15:12] most significant
//   inc    - value + 1, or value itself when already at LIMIT
//   dec    - value - 1, or value itself when already 0000
//   at_max - value equals LIMIT
//   at_min - value equals 0000
module bcd4_step #(
  parameter logic [15:0] LIMIT = 16'h9999
) (
  input  logic [15:0] value,
  output logic [15:0] inc,
  output logic [15:0] dec,
  output logic        at_max,
  output logic        at_min
);

  logic carry;
  logic borrow;

  always_comb begin
    at_max = (value == LIMIT);
    at_min = (value == 16'h0000);
    inc    = value;
    dec    = value;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      // >= 9 rather than == 9 so a stray digit can never propagate a non-BCD value
      if (carry) begin
        if (value[4*i +: 4] >= 4'd9) begin
          inc[4*i +: 4] = 4'd0;
        end else begin
          inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
      if (borrow) begin
        if (value[4*i +: 4] == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
        end else begin
          dec[4*i +: 4] = value[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    if (at_max) inc = value;
    if (at_min) dec = value;
  end

endmodule

// File: rtl/key_counter_ctrl.sv
// Keyboard-controlled BCD counter: K1/K2 key presses select UP, DOWN or HOLD,
// a prescaler produces the count tick while running, and debounced buttons
// step the count while idle or holding.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   en                - 0 freezes the prescaler and hence the counting
//   up_pulse          - one-cycle step-up request
//   down_pulse        - one-cycle step-down request
//   key_valid         - keyboard decoder strobe
//   last_change       - {extend, scancode} of the changed key
//   key_pressed       - 1 on press, 0 on release
//   nums              - four BCD digits of the count
//   led               - [15:12] one-hot state, [0] count at 0000 or LIMIT
module key_counter_ctrl
  import key_counter_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TickDivDefault,
  parameter logic [15:0] LIMIT    = LimitDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up_pulse,
  input  logic        down_pulse,
  input  logic        key_valid,
  input  logic [8:0]  last_change,
  input  logic        key_pressed,
  output logic [15:0] nums,
  output logic [15:0] led
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [15:0]       led_q, led_d;

  logic [15:0] count_inc, count_dec;
  logic        at_max, at_min;

  logic cmd, cmd_k1, cmd_k2;
  logic running, tick;
  logic step_ok, step_up, step_down;

  bcd4_step #(
    .LIMIT (LIMIT)
  ) u_bcd4_step (
    .value  (count_q),
    .inc    (count_inc),
    .dec    (count_dec),
    .at_max (at_max),
    .at_min (at_min)
  );

  assign cmd    = key_valid & key_pressed;
  assign cmd_k1 = cmd && (last_change == KeyK1);
  assign cmd_k2 = cmd && (last_change == KeyK2);

  assign running = (state_q == StUp) || (state_q == StDown);
  assign tick    = running && en && (presc_q == PrescMax);

  // Simultaneous up and down cancel each other
  assign step_ok   = (state_q == StIdle) || (state_q == StHold);
  assign step_up   = step_ok && up_pulse && !down_pulse;
  assign step_down = step_ok && down_pulse && !up_pulse;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;

    // Priority chain: key command, then tick, then button; losers are dropped
    if (cmd_k1) begin
      state_d = (state_q == StUp) ? StHold : StUp;
    end else if (cmd_k2) begin
      state_d = (state_q == StDown) ? StHold : StDown;
    end else if (tick) begin
      if (state_q == StUp) begin
        if (at_max) state_d = StIdle;
        else        count_d = count_inc;
      end else begin
        if (at_min) state_d = StIdle;
        else        count_d = count_dec;
      end
    end else if (step_up) begin
      count_d = count_inc;
    end else if (step_down) begin
      count_d = count_dec;
    end

    if (state_d != state_q) begin
      presc_d = '0;
    end else if (running && en) begin
      presc_d = tick ? '0 : presc_q + PrescW'(1);
    end

    led_d = {state_onehot(state_d), 11'b0, (count_d == 16'h0000) || (count_d == LIMIT)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= 16'h0000;
      presc_q <= '0;
      led_q   <= {state_onehot(StIdle), 11'b0, 1'b1};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      led_q   <= led_d;
    end
  end

  assign nums = count_q;
  assign led  = led_q;

endmodule

// File: tb/tb_key_counter_ctrl.sv
module tb_key_counter_ctrl;

  localparam int unsigned TD      = 4;
  localparam logic [15:0] LIM     = 16'h0012;
  localparam int          LIM_DEC = 12;
  localparam logic [8:0]  K1      = 9'h069;
  localparam logic [8:0]  K2      = 9'h072;

  // Reference model state codes (bench-local, decimal count)
  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_HOLD = 3;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up_pulse;
  logic        down_pulse;
  logic        key_valid;
  logic [8:0]  last_change;
  logic        key_pressed;
  logic [15:0] nums;
  logic [15:0] led;

  int n_checks = 0;
  int n_errors = 0;

  int m_state = M_IDLE;
  int m_count = 0;
  int m_presc = 0;

  key_counter_ctrl #(
    .TICK_DIV (TD),
    .LIMIT    (LIM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_pressed (key_pressed),
    .nums        (nums),
    .led         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int c);
    logic [15:0] r;
    r[15:12] = 4'((c / 1000) % 10);
    r[11:8]  = 4'((c / 100) % 10);
    r[7:4]   = 4'((c / 10) % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  function automatic logic [15:0] exp_led(input int st, input int c);
    logic [15:0] l;
    l = 16'h8000;
    l = l >> st;
    if (c == 0 || c == LIM_DEC) l[0] = 1'b1;
    return l;
  endfunction

  // One clock of the reference behaviour, using the inputs present at the edge
  task automatic model_update();
    int  ns;
    bit  cmd, tick, run;
    if (rst) begin
      m_state = M_IDLE;
      m_count = 0;
      m_presc = 0;
      return;
    end
    ns   = m_state;
    cmd  = key_valid && key_pressed;
    run  = (m_state == M_UP) || (m_state == M_DOWN);
    tick = run && en && (m_presc == TD - 1);
    if (cmd && last_change == K1) begin
      ns = (m_state == M_UP) ? M_HOLD : M_UP;
    end else if (cmd && last_change == K2) begin
      ns = (m_state == M_DOWN) ? M_HOLD : M_DOWN;
    end else if (tick) begin
      if (m_state == M_UP) begin
        if (m_count == LIM_DEC) ns = M_IDLE;
        else m_count = m_count + 1;
      end else begin
        if (m_count == 0) ns = M_IDLE;
        else m_count = m_count - 1;
      end
    end else if ((m_state == M_IDLE || m_state == M_HOLD) && (up_pulse != down_pulse)) begin
      if (up_pulse && m_count < LIM_DEC) m_count = m_count + 1;
      if (down_pulse && m_count > 0) m_count = m_count - 1;
    end
    if (ns != m_state) m_presc = 0;
    else if (run && en) m_presc = (m_presc + 1) % TD;
    m_state = ns;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    up_pulse    = 1'b0;
    down_pulse  = 1'b0;
    key_valid   = 1'b0;
    key_pressed = 1'b0;
  endtask

  task automatic press(input logic [8:0] code);
    key_valid   = 1'b1;
    key_pressed = 1'b1;
    last_change = code;
    step();
  endtask

  task automatic release_key(input logic [8:0] code);
    key_valid   = 1'b1;
    key_pressed = 1'b0;
    last_change = code;
    step();
  endtask

  task automatic btn(input logic u, input logic d);
    up_pulse   = u;
    down_pulse = d;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset must win over a simultaneous command and button
    rst = 1'b1; key_valid = 1'b1; key_pressed = 1'b1; last_change = K1; up_pulse = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (nums !== 16'h0000) begin
      n_errors++; $display("FAIL reset_nums nums=%h expected=%h", nums, 16'h0000);
    end
    n_checks++;
    if (led !== 16'h8001) begin
      n_errors++; $display("FAIL reset_led led=%h expected=%h", led, 16'h8001);
    end
    btn(1'b0, 1'b1);
    n_checks++;
    if (nums !== 16'h0000) begin
      n_errors++; $display("FAIL sat_min nums=%h expected=%h", nums, 16'h0000);
    end
  endtask

  task automatic test_k1_start();
    do_reset();
    press(K1);
    n_checks++;
    if (led !== 16'h4001) begin
      n_errors++; $display("FAIL k1_up_led led=%h expected=%h", led, 16'h4001);
    end
    repeat (3) step();
    n_checks++;
    if (nums !== 16'h0000) begin
      n_errors++; $display("FAIL k1_early_tick nums=%h expected=%h", nums, 16'h0000);
    end
    step();
    n_checks++;
    if (nums !== 16'h0001) begin
      n_errors++; $display("FAIL k1_first_tick nums=%h expected=%h", nums, 16'h0001);
    end
    n_checks++;
    if (led !== 16'h4000) begin
      n_errors++; $display("FAIL k1_first_tick_led led=%h expected=%h", led, 16'h4000);
    end
  endtask

  task automatic test_limit();
    do_reset();
    repeat (11) btn(1'b1, 1'b0);
    n_checks++;
    if (nums !== 16'h0011) begin
      n_errors++; $display("FAIL limit_setup nums=%h expected=%h", nums, 16'h0011);
    end
    press(K1);
    btn(1'b1, 1'b0);  // ignored while running
    n_checks++;
    if (nums !== 16'h0011) begin
      n_errors++; $display("FAIL btn_in_up nums=%h expected=%h", nums, 16'h0011);
    end
    repeat (3) step();
    n_checks++;
    if (nums !== 16'h0012 || led !== 16'h4001) begin
      n_errors++; $display("FAIL limit_reach nums=%h led=%h expected=0012/4001", nums, led);
    end
    repeat (4) step();
    n_checks++;
    if (nums !== 16'h0012 || led !== 16'h8001) begin
      n_errors++; $display("FAIL limit_idle nums=%h led=%h expected=0012/8001", nums, led);
    end
    release_key(K1);
    n_checks++;
    if (nums !== 16'h0012 || led !== 16'h8001) begin
      n_errors++; $display("FAIL release_ignored nums=%h led=%h expected=0012/8001", nums, led);
    end
  endtask

  task automatic test_hold_buttons();
    do_reset();
    repeat (9) btn(1'b1, 1'b0);
    press(K1);
    press(K1);
    n_checks++;
    if (led !== 16'h1000 || nums !== 16'h0009) begin
      n_errors++; $display("FAIL hold_enter led=%h nums=%h expected=1000/0009", led, nums);
    end
    btn(1'b1, 1'b0);
    n_checks++;
    if (nums !== 16'h0010) begin
      n_errors++; $display("FAIL hold_carry nums=%h expected=%h", nums, 16'h0010);
    end
    btn(1'b1, 1'b1);
    n_checks++;
    if (nums !== 16'h0010) begin
      n_errors++; $display("FAIL both_buttons nums=%h expected=%h", nums, 16'h0010);
    end
    btn(1'b0, 1'b1);
    n_checks++;
    if (nums !== 16'h0009) begin
      n_errors++; $display("FAIL hold_borrow nums=%h expected=%h", nums, 16'h0009);
    end
  endtask

  task automatic test_en_freeze();
    do_reset();
    repeat (5) btn(1'b1, 1'b0);
    press(K2);
    n_checks++;
    if (led !== 16'h2000) begin
      n_errors++; $display("FAIL down_led led=%h expected=%h", led, 16'h2000);
    end
    repeat (2) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (nums !== 16'h0005) begin
        n_errors++; $display("FAIL freeze_%0d nums=%h expected=%h", i, nums, 16'h0005);
      end
    end
    en = 1'b1;
    step();
    n_checks++;
    if (nums !== 16'h0005) begin
      n_errors++; $display("FAIL resume_early nums=%h expected=%h", nums, 16'h0005);
    end
    step();
    n_checks++;
    if (nums !== 16'h0004) begin
      n_errors++; $display("FAIL resume_tick nums=%h expected=%h", nums, 16'h0004);
    end
  endtask

  task automatic test_cmd_vs_tick();
    do_reset();
    btn(1'b1, 1'b0);
    press(K1);
    repeat (3) step();
    press(K2);  // lands on the tick edge
    n_checks++;
    if (nums !== 16'h0001 || led !== 16'h2000) begin
      n_errors++; $display("FAIL cmd_beats_tick nums=%h led=%h expected=0001/2000", nums, led);
    end
    repeat (3) step();
    n_checks++;
    if (nums !== 16'h0001) begin
      n_errors++; $display("FAIL presc_cleared nums=%h expected=%h", nums, 16'h0001);
    end
    step();
    n_checks++;
    if (nums !== 16'h0000 || led !== 16'h2001) begin
      n_errors++; $display("FAIL down_tick nums=%h led=%h expected=0000/2001", nums, led);
    end
    repeat (4) step();
    n_checks++;
    if (nums !== 16'h0000 || led !== 16'h8001) begin
      n_errors++; $display("FAIL down_floor nums=%h led=%h expected=0000/8001", nums, led);
    end
  endtask

  task automatic test_reset_mid_tick();
    do_reset();
    repeat (7) btn(1'b1, 1'b0);
    press(K1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (nums !== 16'h0000 || led !== 16'h8001) begin
      n_errors++; $display("FAIL reset_mid_tick nums=%h led=%h expected=0000/8001", nums, led);
    end
    step();
    n_checks++;
    if (nums !== 16'h0000 || led !== 16'h8001) begin
      n_errors++; $display("FAIL after_reset nums=%h led=%h expected=0000/8001", nums, led);
    end
  endtask

  task automatic test_random();
    logic [8:0]  codes [6];
    logic [15:0] e_nums, e_led;
    int          errs_here;
    codes = '{9'h069, 9'h072, 9'h169, 9'h172, 9'h01c, 9'h069};
    errs_here = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      en         = ($urandom_range(0, 9) != 0);
      up_pulse   = ($urandom_range(0, 3) == 0);
      down_pulse = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 6) begin
        key_valid   = 1'b1;
        key_pressed = ($urandom_range(0, 3) != 0);
        last_change = codes[$urandom_range(0, 5)];
      end
      step();
      e_nums = to_bcd(m_count);
      e_led  = exp_led(m_state, m_count);
      n_checks++;
      if (nums !== e_nums || led !== e_led) begin
        n_errors++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL random_%0d nums=%h led=%h expected=%h/%h", i, nums, led, e_nums, e_led);
      end
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    en          = 1'b1;
    up_pulse    = 1'b0;
    down_pulse  = 1'b0;
    key_valid   = 1'b0;
    key_pressed = 1'b0;
    last_change = 9'h000;
    test_reset();
    test_k1_start();
    test_limit();
    test_hold_buttons();
    test_en_freeze();
    test_cmd_vs_tick();
    test_reset_mid_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
